// File: rtl/dcache_wb_if.sv
// dcache_wb_if: bundles the processor D-cache port and the 128-bit line
// memory port of dcache_wb.
//   slave  : the cache side (consumes proc_* requests, initiates mem_* transfers)
//   master : the environment side (pipeline MEM stage plus memory model/arbiter)
// Processor side: proc_read/proc_write/proc_addr/proc_wdata in, proc_stall/proc_rdata out.
// Memory side   : mem_read/mem_write/mem_addr/mem_wdata out, mem_ready/mem_rdata in.
interface dcache_wb_if;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic         mem_ready;
   logic [127:0] mem_rdata;

   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
      output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
      input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache with
// 4-word (128-bit) lines.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (invalidates every line)
//   bus      : dcache_wb_if.slave -- processor request/response plus line memory port
//   hit_cnt  : (DCACHE_PERF_EN only) requests that hit on first presentation
//   miss_cnt : (DCACHE_PERF_EN only) misses, one per refill/eviction sequence
// Optional feature macro: DCACHE_PERF_EN adds the performance counters.
//
// state | meaning
// IDLE  | serving hits; a miss launches WB or ALLOC
// WB    | dirty victim line being written back, waiting for mem_ready
// ALLOC | refill of the requested line, waiting for mem_ready
module dcache_wb #(
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 25
) (
   input  logic         clk,
   input  logic         rst_n,
   dcache_wb_if.slave   bus
`ifdef DCACHE_PERF_EN
   ,
   output logic [31:0]  hit_cnt,
   output logic [31:0]  miss_cnt
`endif
);
   localparam int NUM_SETS = 2**INDEX_W;

   typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, ALLOC = 2'd2} state_t;

   state_t               state;
   logic [NUM_SETS-1:0]  valid;
   logic [NUM_SETS-1:0]  dirty;
   logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
   logic [127:0]         data_mem [NUM_SETS];

   logic [INDEX_W-1:0]   idx;
   logic [TAG_W-1:0]     req_tag;
   logic [1:0]           off;
   logic [127:0]         line;
   logic                 req;
   logic                 hit;

   assign idx     = bus.proc_addr[INDEX_W+1:2];
   assign req_tag = bus.proc_addr[29:INDEX_W+2];
   assign off     = bus.proc_addr[1:0];
   assign line    = data_mem[idx];
   assign req     = bus.proc_read | bus.proc_write;
   assign hit     = valid[idx] && (tag_mem[idx] == req_tag);

   assign bus.proc_stall = (state != IDLE) || (req && !hit);
   // a simultaneous write wins, so a read only returns data when alone
   assign bus.proc_rdata = (state == IDLE && bus.proc_read && !bus.proc_write && hit)
                           ? line[{off, 5'b0} +: 32] : 32'd0;

   // Tag/data arrays carry no reset; valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.proc_write && hit) begin
         data_mem[idx][{off, 5'b0} +: 32] <= bus.proc_wdata;
      end else if (state == ALLOC && bus.mem_ready) begin
         data_mem[idx] <= bus.mem_rdata;
         tag_mem[idx]  <= req_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         valid         <= '0;
         dirty         <= '0;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req && !hit) begin
                  if (valid[idx] && dirty[idx]) begin
                     state         <= WB;
                     bus.mem_write <= 1'b1;
                     bus.mem_addr  <= {tag_mem[idx], idx};
                     bus.mem_wdata <= line;
                  end else begin
                     state        <= ALLOC;
                     bus.mem_read <= 1'b1;
                     bus.mem_addr <= {req_tag, idx};
                  end
               end else if (bus.proc_write && hit) begin
                  dirty[idx] <= 1'b1;
               end
            end
            WB: begin
               if (bus.mem_ready) begin
                  state         <= ALLOC;
                  bus.mem_write <= 1'b0;
                  bus.mem_read  <= 1'b1;
                  bus.mem_addr  <= {req_tag, idx};
               end
            end
            ALLOC: begin
               if (bus.mem_ready) begin
                  state        <= IDLE;
                  bus.mem_read <= 1'b0;
                  valid[idx]   <= 1'b1;
                  dirty[idx]   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_PERF_EN
   // The request that caused a refill hits one cycle after ALLOC; that
   // completion belongs to the miss, so just_filled masks it from hit_cnt.
   logic just_filled;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt     <= '0;
         miss_cnt    <= '0;
         just_filled <= 1'b0;
      end else begin
         just_filled <= (state == ALLOC) && bus.mem_ready;
         if (state == IDLE && req && hit && !just_filled) hit_cnt <= hit_cnt + 32'd1;
         if (state == IDLE && req && !hit) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dcache_wb.sv
module tb_dcache_wb;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dcache_wb_if bus ();
`ifdef DCACHE_PERF_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   dcache_wb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef DCACHE_PERF_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit           wr;
      logic [27:0]  addr;
      logic [127:0] data;
   } mem_op_t;

   logic [31:0]  rd_exp_q [$];
   mem_op_t      mem_q [$];
   logic [127:0] mem_lines [logic [27:0]];
   int           fix_lat = 0;

   // reference model: architectural word view over a backing memory,
   // plus which line each set currently holds
   logic [31:0]  view_w    [logic [29:0]];
   logic [31:0]  backing_w [logic [29:0]];
   bit           m_valid [8];
   bit           m_dirty [8];
   logic [24:0]  m_tag   [8];
   int           exp_hits = 0;
   int           exp_miss = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: event not expected / not seen", name);
   endtask

   function automatic logic [31:0] init_word(input logic [29:0] a);
      logic [31:0] x;
      x = {2'b00, a};
      return x ^ 32'hC0DE_0000 ^ (x << 11);
   endfunction

   function automatic logic [31:0] rd_backing(input logic [29:0] a);
      if (backing_w.exists(a)) return backing_w[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] rd_view(input logic [29:0] a);
      if (view_w.exists(a)) return view_w[a];
      return rd_backing(a);
   endfunction

   function automatic logic [127:0] refill(input logic [27:0] la);
      logic [127:0] l;
      if (mem_lines.exists(la)) return mem_lines[la];
      for (int k = 0; k < 4; k++) l[32*k +: 32] = init_word({la, k[1:0]});
      return l;
   endfunction

   task automatic preload(input logic [27:0] la, input logic [127:0] l);
      mem_lines[la] = l;
      for (int k = 0; k < 4; k++) backing_w[{la, k[1:0]}] = l[32*k +: 32];
   endtask

   task automatic model_access(input bit rd, input bit wr, input logic [29:0] a,
                               input logic [31:0] wd, output bit hit, output logic [31:0] er);
      int           s;
      logic [24:0]  t;
      logic [27:0]  vla;
      logic [127:0] l;
      mem_op_t      op;
      s = int'(a[4:2]);
      t = a[29:5];
      hit = m_valid[s] && (m_tag[s] == t);
      if (hit) exp_hits++;
      else begin
         exp_miss++;
         if (m_valid[s] && m_dirty[s]) begin
            vla = {m_tag[s], a[4:2]};
            for (int k = 0; k < 4; k++) begin
               l[32*k +: 32] = rd_view({vla, k[1:0]});
               backing_w[{vla, k[1:0]}] = l[32*k +: 32];
            end
            op.wr = 1'b1; op.addr = vla; op.data = l;
            mem_q.push_back(op);
         end
         op.wr = 1'b0; op.addr = a[29:2]; op.data = '0;
         mem_q.push_back(op);
         m_valid[s] = 1'b1;
         m_tag[s]   = t;
         m_dirty[s] = 1'b0;
      end
      er = (rd && !wr) ? rd_view(a) : 32'd0;
      if (wr) begin
         view_w[a]  = wd;
         m_dirty[s] = 1'b1;
      end
   endtask

   task automatic do_op(input bit rd, input bit wr, input logic [29:0] a,
                        input logic [31:0] wd, output int stalls);
      bit          hit;
      bit          done;
      logic [31:0] er;
      @(posedge clk); #1;
      model_access(rd, wr, a, wd, hit, er);
      rd_exp_q.push_back(er);
      bus.proc_read  = rd;
      bus.proc_write = wr;
      bus.proc_addr  = a;
      bus.proc_wdata = wd;
      stalls = 0;
      done   = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (!bus.proc_stall) done = 1'b1;
         else begin
            stalls++;
            if (stalls > 300) begin
               fail("stall_timeout");
               done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
      check("hit_vs_model", 128'(stalls == 0), 128'(hit));
   endtask

   task automatic rand_ops(input int n);
      int          st;
      int          kind;
      logic [29:0] a;
      for (int i = 0; i < n; i++) begin
         a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         kind = $urandom_range(0, 5);
         do_op(kind <= 2 || kind == 5, kind >= 3, a, $urandom, st);
      end
   endtask

   // processor-side monitor: one comparison per completed request
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && (bus.proc_read || bus.proc_write) && !bus.proc_stall) begin
            if (rd_exp_q.size() == 0) fail("rdata_unexpected");
            else check("proc_rdata", bus.proc_rdata, rd_exp_q.pop_front());
         end
      end
   end

   // memory responder and memory-side monitor
   initial begin
      mem_op_t op;
      int      lat;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && (bus.mem_read || bus.mem_write)) begin
            check("mem_rd_wr_exclusive", 128'(bus.mem_read && bus.mem_write), 128'(0));
            if (mem_q.size() == 0) fail("mem_unexpected");
            else begin
               op = mem_q.pop_front();
               check("mem_is_write", 128'(bus.mem_write), 128'(op.wr));
               check("mem_addr", 128'(bus.mem_addr), 128'(op.addr));
               if (op.wr) check("mem_wdata", bus.mem_wdata, op.data);
            end
            lat = (fix_lat != 0) ? fix_lat : $urandom_range(1, 4);
            repeat (lat - 1) @(negedge clk);
            if (bus.mem_write) mem_lines[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata = refill(bus.mem_addr);
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          st;
      int          waited;
      logic [29:0] a;
      bit          hit;
      logic [31:0] er;

      rst_n          = 1'b0;
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
      bus.proc_addr  = '0;
      bus.proc_wdata = '0;
      for (int s = 0; s < 8; s++) begin
         m_valid[s] = 1'b0; m_dirty[s] = 1'b0; m_tag[s] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_mem_read", 128'(bus.mem_read), 128'(0));
      check("reset_mem_write", 128'(bus.mem_write), 128'(0));
      check("reset_mem_addr", 128'(bus.mem_addr), 128'(0));
      check("reset_mem_wdata", bus.mem_wdata, 128'(0));
      check("reset_proc_stall", 128'(bus.proc_stall), 128'(0));
      check("reset_proc_rdata", 128'(bus.proc_rdata), 128'(0));
`ifdef DCACHE_PERF_EN
      check("reset_hit_cnt", 128'(hit_cnt), 128'(0));
      check("reset_miss_cnt", 128'(miss_cnt), 128'(0));
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;

      // directed plan: cold read, read hit, write hit, dirty conflict, clean conflict
      preload(28'h4, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
      fix_lat = 5;
      do_op(1'b1, 1'b0, 30'h10, 32'd0, st);
      check("cold_read_stall_cycles", 128'(st), 128'(6));
      fix_lat = 0;
      do_op(1'b1, 1'b0, 30'h12, 32'd0, st);
      check("read_hit_stall_cycles", 128'(st), 128'(0));
      do_op(1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF, st);
      do_op(1'b1, 1'b0, 30'h110, 32'd0, st);
      check("dirty_victim_word1", mem_lines[28'h4][63:32], 128'(32'hDEAD_BEEF));
`ifdef DCACHE_PERF_EN
      check("plan_hit_cnt", 128'(hit_cnt), 128'(2));
      check("plan_miss_cnt", 128'(miss_cnt), 128'(2));
`endif
      do_op(1'b1, 1'b0, 30'h10, 32'd0, st);
      do_op(1'b1, 1'b1, 30'h13, 32'h1234_5678, st);

      rand_ops(300);
`ifdef DCACHE_PERF_EN
      check("rand_hit_cnt", 128'(hit_cnt), 128'(exp_hits));
      check("rand_miss_cnt", 128'(miss_cnt), 128'(exp_miss));
`endif

      // reset while a refill is outstanding
      a = {25'd5, 3'd4, 2'd1};
      @(posedge clk); #1;
      model_access(1'b1, 1'b0, a, 32'd0, hit, er);
      bus.proc_read = 1'b1;
      bus.proc_addr = a;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.mem_read && waited < 60);
      if (!bus.mem_read) fail("alloc_not_reached");
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.proc_read = 1'b0;
      #1;
      check("rst_mid_alloc_mem_read", 128'(bus.mem_read), 128'(0));
      check("rst_mid_alloc_proc_stall", 128'(bus.proc_stall), 128'(0));
      for (int s = 0; s < 8; s++) begin
         m_valid[s] = 1'b0; m_dirty[s] = 1'b0;
      end
      view_w.delete();
      mem_q.delete();
      exp_hits = 0;
      exp_miss = 0;
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      do_op(1'b1, 1'b0, 30'h10, 32'd0, st);
      check("post_reset_miss", 128'(st > 0), 128'(1));
      rand_ops(80);
`ifdef DCACHE_PERF_EN
      check("post_reset_hit_cnt", 128'(hit_cnt), 128'(exp_hits));
      check("post_reset_miss_cnt", 128'(miss_cnt), 128'(exp_miss));
`endif

      repeat (10) @(posedge clk);
      check("rdata_queue_drained", 128'(rd_exp_q.size()), 128'(0));
      check("mem_queue_drained", 128'(mem_q.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Responder on the processor D-cache port: consumes word-addressed read/write requests from the pipeline's MEM stage and returns data or stall.
- Initiator on a 128-bit line-wide memory port for refills and dirty evictions.
- Sits between the pipeline's DCACHE interface and the memory model/arbiter.

Parameters:
- INDEX_W, 3, index bits; NUM_SETS = 2**INDEX_W = 8 lines.
- TAG_W, 25, tag bits; must equal 30 - 2 - INDEX_W.
- Line size is fixed at 4 words / 128 bits (not a parameter).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- proc_read  input  1  read request, held until proc_stall low
- proc_write  input  1  write request, held until proc_stall low
- proc_addr  input  30  word address: [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag
- proc_wdata  input  32  store data (stored verbatim, no byte swap)
- proc_stall  output  1  request not yet complete
- proc_rdata  output  32  load data, valid when proc_read=1 and proc_stall=0
- mem_read  output  1  line refill request
- mem_write  output  1  line writeback request
- mem_addr  output  28  line address {tag,index}
- mem_wdata  output  128  victim line, word 0 in [31:0]
- mem_ready  input  1  one-cycle pulse: refill data valid / writeback accepted
- mem_rdata  input  128  refill line, word 0 in [31:0]

Behaviour:
- Storage per set: valid, dirty, tag[TAG_W-1:0], data[127:0].
- Reset: all valid and dirty bits = 0, state = IDLE, mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0. Data/tag arrays need no reset.
- hit = valid[idx] & (tag[idx] == req_tag); req = proc_read | proc_write.
- proc_stall is combinational: 1 when (state == IDLE & req & ~hit) or state != IDLE; otherwise 0. With no request, proc_stall = 0.
- proc_rdata = selected word of the indexed line when proc_read & hit & state == IDLE; otherwise 0. Read hit latency is 0 cycles.
- Write hit in IDLE: at the clock edge, write proc_wdata into the selected word and set dirty = 1. No stall.
- If proc_read and proc_write are both 1, the write takes priority and proc_rdata = 0.
- FSM states and transitions:
  - IDLE:
    - req & ~hit & valid & dirty -> WB. Register mem_write = 1, mem_addr = {victim tag, idx}, mem_wdata = victim line.
    - req & ~hit, otherwise -> ALLOC. Register mem_read = 1, mem_addr = {req_tag, idx}.
  - WB: hold all memory outputs stable. On mem_ready -> ALLOC. Same edge: mem_write = 0, mem_read = 1, mem_addr = {req_tag, idx}.
  - ALLOC: hold. On mem_ready:
    - line = mem_rdata, tag = req_tag, valid = 1, dirty = 0, mem_read = 0 -> IDLE.
    - The request then hits on the following cycle (total miss cost = memory latency + 1 cycle).
- mem_read and mem_write are never high together; both are registered outputs.
- A mem_ready arriving in IDLE is ignored.
- The processor holds proc_addr/proc_wdata stable while stalled. The cache does not latch the request.
- Reset asserted mid-WB or mid-ALLOC: immediate return to IDLE, memory requests drop, all lines invalidated. The partially transferred line is discarded.

Optional Feature:
- Macro: DCACHE_PERF_EN.
- Defined: adds output ports hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
  - hit_cnt increments once per completed request that hit on first presentation.
  - miss_cnt increments once per IDLE->WB or IDLE->ALLOC transition.
  - The post-refill hit cycle does not count as a hit.
  - Counters wrap at 2**32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Cold read, proc_addr = 0x00000010, memory line = {D,C,B,A}, mem_ready 5 cycles after mem_read:
  - Expect mem_read with mem_addr = 0x0000004, no mem_write.
  - proc_stall high 6 cycles, then proc_rdata = A, stall low.
- Read hit, same block proc_addr = 0x00000012 -> proc_stall = 0 same cycle, proc_rdata = C, no memory traffic.
- Write hit to 0x00000011 with 0xDEADBEEF, then read of conflicting address 0x00000110 (same index, tag 8):
  - Expect mem_write with mem_addr = 0x0000004 and mem_wdata[63:32] = 0xDEADBEEF.
  - Then mem_read with mem_addr = 0x0000044, then data returned.
- Clean conflict miss (line never written) -> ALLOC only, mem_write never asserted.
- rst_n pulsed low while in ALLOC -> mem_read = 0 immediately, proc_stall = 0 with no request, and the previously valid address misses again afterward.
- With DCACHE_PERF_EN: sequence cold miss, hit, hit, conflict miss -> hit_cnt = 2, miss_cnt = 2.
